glyph_serializer: RTL and testbench

Parametrised character generator for the mcvideo path. Accepts one (character, row) request per glyph row over a valid/ready handshake and looks up the glyph row in an internal font ROM. It then emits that row as a one-pixel-per-cycle dot stream with backpressure, framing and optional attributes. It sits between the text-buffer scanner and the video output shifter, replacing the fixed 8x8, x/y-addressed character_rom lookup.

---
 rtl/mcvideo_pkg.sv | 22 ++
 rtl/glyph_row_rom.sv | 30 +++
 rtl/glyph_serializer.sv | 143 ++++++++++++++
 tb/tb_glyph_serializer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mcvideo_pkg.sv
// Shared types and constants for the mcvideo character path.
package mcvideo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2
  } glyph_ser_state_t;

  localparam int ATTR_INVERT    = 0;
  localparam int ATTR_UNDERLINE = 1;

  localparam int GLYPH_W_DEF    = 8;
  localparam int GLYPH_H_DEF    = 8;
  localparam int CHAR_BITS_DEF  = 7;

  // Row index width; a single-row font still needs one address bit.
  function automatic int row_bits(input int h);
    return (h > 1) ? $clog2(h) : 1;
  endfunction

endpackage

// File: rtl/glyph_row_rom.sv
// Font ROM: one GLYPH_W-bit word per glyph row, address = char*GLYPH_H + row.
module glyph_row_rom
  import mcvideo_pkg::*;
#(
  parameter int    GLYPH_W   = GLYPH_W_DEF,
  parameter int    GLYPH_H   = GLYPH_H_DEF,
  parameter int    CHAR_BITS = CHAR_BITS_DEF,
  parameter string FONT_FILE = "font.hex",
  localparam int   RW        = row_bits(GLYPH_H),
  localparam int   AW        = CHAR_BITS + RW
) (
  input  logic [AW-1:0]      addr,
  input  logic [RW-1:0]      row,
  output logic [GLYPH_W-1:0] data
);

  localparam int DEPTH = (2 ** CHAR_BITS) * GLYPH_H;

  logic [GLYPH_W-1:0] mem [DEPTH];

  // Rows past the glyph height would alias into the next character, so they read as blank.
  always_comb begin
    if (int'(row) < GLYPH_H) begin
      data = mem[addr];
    end else begin
      data = '0;
    end
  end

endmodule

// File: rtl/glyph_serializer.sv
// Glyph row lookup and dot serializer with valid/ready on both sides.
// Optional invert/underline attributes are enabled by GLYPH_SERIALIZER_ATTR_EN.
module glyph_serializer
  import mcvideo_pkg::*;
#(
  parameter int    GLYPH_W   = GLYPH_W_DEF,
  parameter int    GLYPH_H   = GLYPH_H_DEF,
  parameter int    CHAR_BITS = CHAR_BITS_DEF,
  parameter string FONT_FILE = "font.hex",
  localparam int   RW        = row_bits(GLYPH_H)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CHAR_BITS-1:0] req_char,
  input  logic [RW-1:0]        req_row,
  input  logic [1:0]           req_attr,
  output logic                 dot_valid,
  output logic                 dot,
  output logic                 dot_last,
  input  logic                 dot_ready
);

  localparam int AW = CHAR_BITS + RW;
  localparam int CW = $clog2(GLYPH_W);

  glyph_ser_state_t   state_r;
  logic [AW-1:0]      addr_r;
  logic [RW-1:0]      row_r;
  logic [GLYPH_W-1:0] shift_r;
  logic [CW-1:0]      cnt_r;
  logic               dot_valid_r;
  logic               dot_r;
  logic               dot_last_r;
  logic [AW-1:0]      addr_s;
  logic [GLYPH_W-1:0] rom_word_s;
  logic [GLYPH_W-1:0] word_s;
  logic               accept_s;

  assign addr_s    = AW'(req_char) * AW'(GLYPH_H) + AW'(req_row);
  assign req_ready = ~reset & ((state_r == IDLE) |
                               ((state_r == SHIFT) & dot_last_r & dot_ready));
  assign accept_s  = req_valid & req_ready;

  assign dot_valid = dot_valid_r;
  assign dot       = dot_r;
  assign dot_last  = dot_last_r;

  glyph_row_rom #(
    .GLYPH_W   (GLYPH_W),
    .GLYPH_H   (GLYPH_H),
    .CHAR_BITS (CHAR_BITS),
    .FONT_FILE (FONT_FILE)
  ) u_rom (
    .addr (addr_r),
    .row  (row_r),
    .data (rom_word_s)
  );

`ifdef GLYPH_SERIALIZER_ATTR_EN
  logic [1:0]         attr_r;
  logic [GLYPH_W-1:0] ul_word_s;

  // Underline only paints the bottom row, and is applied before invert.
  assign ul_word_s = (attr_r[ATTR_UNDERLINE] && (int'(row_r) == GLYPH_H - 1)) ? '1 : rom_word_s;
  assign word_s    = attr_r[ATTR_INVERT] ? ~ul_word_s : ul_word_s;

  // Attribute capture at request acceptance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      attr_r <= 2'b00;
    end else if (accept_s) begin
      attr_r <= req_attr;
    end
  end
`else
  logic unused_attr_s;

  assign unused_attr_s = ^req_attr;
  assign word_s        = rom_word_s;
`endif

  // Request capture, fetch and dot shifting state machine.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      addr_r      <= '0;
      row_r       <= '0;
      shift_r     <= '0;
      cnt_r       <= '0;
      dot_valid_r <= 1'b0;
      dot_r       <= 1'b0;
      dot_last_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            addr_r  <= addr_s;
            row_r   <= req_row;
            state_r <= FETCH;
          end
        end
        FETCH: begin
          shift_r     <= word_s;
          cnt_r       <= '0;
          dot_valid_r <= 1'b1;
          dot_r       <= word_s[GLYPH_W-1];
          dot_last_r  <= 1'b0;
          state_r     <= SHIFT;
        end
        SHIFT: begin
          if (dot_ready) begin
            if (dot_last_r) begin
              dot_valid_r <= 1'b0;
              dot_r       <= 1'b0;
              dot_last_r  <= 1'b0;
              if (accept_s) begin
                addr_r  <= addr_s;
                row_r   <= req_row;
                state_r <= FETCH;
              end else begin
                state_r <= IDLE;
              end
            end else begin
              shift_r    <= shift_r << 1;
              cnt_r      <= cnt_r + 1'b1;
              dot_r      <= shift_r[GLYPH_W-2];
              dot_last_r <= (cnt_r == CW'(GLYPH_W - 2));
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          dot_valid_r <= 1'b0;
          dot_r       <= 1'b0;
          dot_last_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glyph_serializer.sv
// Directed bench for glyph_serializer: an 8x8 instance and an 8x6 instance share stimulus.
module tb_glyph_serializer;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       dot_ready;
  logic [6:0] req_char;
  logic [2:0] req_row;
  logic [1:0] req_attr;

  logic rdy8, v8, d8, l8;
  logic rdy6, v6, d6, l6;
  logic sel6;
  logic o_rdy, o_v, o_d, o_l;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clock = ~clock;

  glyph_serializer #(.GLYPH_W(8), .GLYPH_H(8), .CHAR_BITS(7), .FONT_FILE("")) dut8 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(rdy8),
    .req_char(req_char), .req_row(req_row), .req_attr(req_attr),
    .dot_valid(v8), .dot(d8), .dot_last(l8), .dot_ready(dot_ready)
  );

  glyph_serializer #(.GLYPH_W(8), .GLYPH_H(6), .CHAR_BITS(7), .FONT_FILE("")) dut6 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(rdy6),
    .req_char(req_char), .req_row(req_row), .req_attr(req_attr),
    .dot_valid(v6), .dot(d6), .dot_last(l6), .dot_ready(dot_ready)
  );

  assign o_rdy = sel6 ? rdy6 : rdy8;
  assign o_v   = sel6 ? v6   : v8;
  assign o_d   = sel6 ? d6   : d8;
  assign o_l   = sel6 ? l6   : l8;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Present a request at the falling edge; it is accepted on the next rising edge.
  task automatic present(input logic [6:0] c, input logic [2:0] r, input logic [1:0] a);
    @(negedge clock);
    req_valid = 1'b1;
    req_char  = c;
    req_row   = r;
    req_attr  = a;
    #1;
    check("accept_ready", o_rdy, 1);
  endtask

  // FETCH cycle: no dot; request fields are scrambled to show they were already sampled.
  task automatic bubble(input string tag);
    @(negedge clock);
    req_valid = 1'b0;
    req_char  = 7'd66;
    req_row   = 3'd3;
    req_attr  = ~req_attr;
    #1;
    check(tag, o_v, 0);
  endtask

  task automatic expect_row(input string tag, input logic [7:0] exp, input int npix,
                            input int stall_px, input logic nv, input logic [6:0] nc,
                            input logic [2:0] nr, input logic [1:0] na);
    for (int i = 0; i < npix; i++) begin
      @(negedge clock);
      if (i == stall_px) begin
        dot_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          #1;
          check($sformatf("%s_stall%0d", tag, k), {o_v, o_d, o_l}, {1'b1, exp[7-i], (i == 7)});
          @(negedge clock);
        end
        dot_ready = 1'b1;
      end
      if (i == 7 && nv) begin
        req_valid = 1'b1;
        req_char  = nc;
        req_row   = nr;
        req_attr  = na;
      end
      #1;
      check($sformatf("%s_p%0d", tag, i), {o_v, o_d, o_l}, {1'b1, exp[7-i], (i == 7)});
      if (i == 7) check({tag, "_last_ready"}, o_rdy, 1);
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clock);
    #1;
    check({tag, "_valid"}, o_v, 0);
    check({tag, "_ready"}, o_rdy, 1);
  endtask

  logic [7:0] exp_inv, exp_ul, exp_ulinv;

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_char  = 7'd0;
    req_row   = 3'd0;
    req_attr  = 2'b00;
    dot_ready = 1'b1;
    sel6      = 1'b0;
`ifdef GLYPH_SERIALIZER_ATTR_EN
    exp_inv   = 8'hE7;
    exp_ul    = 8'hFF;
    exp_ulinv = 8'h00;
`else
    exp_inv   = 8'h18;
    exp_ul    = 8'h00;
    exp_ulinv = 8'h00;
`endif
    for (int i = 0; i < 8; i++) dut8.u_rom.mem[65*8+i] = 8'h3C;
    dut8.u_rom.mem[65*8+0] = 8'h18;
    dut8.u_rom.mem[65*8+7] = 8'h00;
    dut6.u_rom.mem[65*6+0] = 8'h81;
    for (int i = 1; i < 6; i++) dut6.u_rom.mem[65*6+i] = 8'hFF;
    dut6.u_rom.mem[66*6+0] = 8'hA5;
    dut6.u_rom.mem[66*6+1] = 8'h5A;

    #1;
    check("rst_ready", o_rdy, 0);
    check("rst_outputs", {o_v, o_d, o_l}, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rel_ready", o_rdy, 1);
    check("rel_valid", o_v, 0);

    present(7'd65, 3'd0, 2'b00); bubble("basic_bubble");
    expect_row("basic", 8'h18, 8, -1, 1'b0, 7'd0, 3'd0, 2'b00); idle_check("basic_idle");

    present(7'd65, 3'd0, 2'b00); bubble("bp_bubble");
    expect_row("bp", 8'h18, 8, 3, 1'b0, 7'd0, 3'd0, 2'b00); idle_check("bp_idle");

    present(7'd65, 3'd0, 2'b00); bubble("b2b_bubble1");
    expect_row("b2b_first", 8'h18, 8, -1, 1'b1, 7'd65, 3'd7, 2'b00);
    bubble("b2b_bubble2");
    expect_row("b2b_second", 8'h00, 8, -1, 1'b0, 7'd0, 3'd0, 2'b00); idle_check("b2b_idle");

    present(7'd65, 3'd0, 2'b01); bubble("inv_bubble");
    expect_row("attr_inv", exp_inv, 8, -1, 1'b0, 7'd0, 3'd0, 2'b00);
    present(7'd65, 3'd7, 2'b10); bubble("ul_bubble");
    expect_row("attr_ul", exp_ul, 8, -1, 1'b0, 7'd0, 3'd0, 2'b00);
    present(7'd65, 3'd7, 2'b11); bubble("ulinv_bubble");
    expect_row("attr_ulinv", exp_ulinv, 8, -1, 1'b0, 7'd0, 3'd0, 2'b00);
    present(7'd65, 3'd0, 2'b10); bubble("ulrow0_bubble");
    expect_row("attr_ul_row0", 8'h18, 8, -1, 1'b0, 7'd0, 3'd0, 2'b00); idle_check("attr_idle");

    sel6 = 1'b1;
    present(7'd65, 3'd0, 2'b00); bubble("h6_bubble0");
    expect_row("h6_row0", 8'h81, 8, -1, 1'b0, 7'd0, 3'd0, 2'b00);
    present(7'd65, 3'd6, 2'b00); bubble("h6_bubble6");
    expect_row("h6_row6", 8'h00, 8, -1, 1'b0, 7'd0, 3'd0, 2'b00);
    present(7'd65, 3'd7, 2'b00); bubble("h6_bubble7");
    expect_row("h6_row7", 8'h00, 8, -1, 1'b0, 7'd0, 3'd0, 2'b00); idle_check("h6_idle");
    sel6 = 1'b0;

    present(7'd65, 3'd0, 2'b00); bubble("mid_bubble");
    expect_row("mid_row", 8'h18, 4, -1, 1'b0, 7'd0, 3'd0, 2'b00);
    @(negedge clock);
    #1;
    check("mid_p4", {o_v, o_d, o_l}, 3'b110);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", o_v, 0);
    check("mid_rst_ready", o_rdy, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid_rel_ready", o_rdy, 1);
    check("mid_rel_valid", o_v, 0);
    present(7'd65, 3'd0, 2'b00); bubble("after_bubble");
    expect_row("after_row", 8'h18, 8, -1, 1'b0, 7'd0, 3'd0, 2'b00); idle_check("after_idle");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
